// File: rtl/backprop_chain_engine_pkg.sv
// Shared types and fixed-point helpers for the backprop chain engine.
// Helpers work on wide containers so any DATA_W <= 32, accumulator <= 64 fits.
package backprop_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Floor shift by frac_w, then clamp to the signed data_w range.
  function automatic logic signed [31:0] sat_shift(input logic signed [63:0] acc,
                                                   input int frac_w, input int data_w);
    logic signed [63:0] sh, hi, lo;
    sh = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sh > hi)      sh = hi;
    else if (sh < lo) sh = lo;
    return sh[31:0];
  endfunction

  // One lane of the one-hot seed: 1.0 where selected, else 0.
  function automatic logic [31:0] one_hot_seed(input logic sel, input int frac_w);
    return sel ? (32'd1 << frac_w) : 32'd0;
  endfunction

endpackage

// File: rtl/backprop_chain_engine_if.sv
// Job control, row stream and read-out bundle of the backprop chain engine.
interface backprop_chain_engine_if #(
  parameter int DATA_W  = 16,
  parameter int N       = 3,
  parameter int LAYER_W = 32
);
  logic                start;
  logic [LAYER_W-1:0]  num_layers;
  logic                seed_mode;
  logic [DATA_W*N-1:0] seed_vec;
  logic [N-1:0]        seed_sel;
  logic                row_valid;
  logic                row_ready;
  logic [DATA_W*N-1:0] row_data;
  logic [LAYER_W-1:0]  rd_addr;
  logic [N-1:0]        rd_mask;
  logic [DATA_W*N-1:0] rd_data;
  logic                busy;
  logic                done;

  modport master (
    output start, num_layers, seed_mode, seed_vec, seed_sel, row_valid, row_data,
           rd_addr, rd_mask,
    input  row_ready, rd_data, busy, done
  );

  modport slave (
    input  start, num_layers, seed_mode, seed_vec, seed_sel, row_valid, row_data,
           rd_addr, rd_mask,
    output row_ready, rd_data, busy, done
  );
endinterface

// File: rtl/backprop_chain_engine_fxp_dot_row.sv
// One matrix row times the current vector: N signed multipliers, adder tree,
// floor shift with saturation, one register stage.
module fxp_dot_row
  import backprop_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  input  logic [N-1:0][DATA_W-1:0] row_i,
  input  logic [N-1:0][DATA_W-1:0] vec_i,
  output logic                   out_valid_o,
  output logic [DATA_W-1:0]      out_data_o
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(N);

  logic signed [PROD_W-1:0] prod [N];
  logic signed [ACC_W-1:0]  acc_d;
  logic                     vld_q;
  logic [DATA_W-1:0]        out_q;

  for (genvar g = 0; g < N; g++) begin : g_mul
    assign prod[g] = PROD_W'($signed(row_i[g])) * PROD_W'($signed(vec_i[g]));
  end

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < N; i++) acc_d = acc_d + ACC_W'(prod[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      out_q <= '0;
    end else begin
      vld_q <= in_valid_i;
      if (in_valid_i) out_q <= DATA_W'(sat_shift(64'(acc_d), FRAC_W, DATA_W));
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = out_q;
endmodule

// File: rtl/backprop_chain_engine.sv
// Chained matrix-vector engine: v(k+1) = M(k)*v(k), one streamed row per beat,
// every layer result kept in a buffer with a masked, registered read-out.
module backprop_chain_engine
  import backprop_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int N          = 3,
  parameter int MAX_LAYERS = 5,
  parameter int LAYER_W    = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  backprop_chain_engine_if.slave bus
);
  localparam int AW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][DATA_W-1:0] vec_t;

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layers_q, layer_q, l_clamp;
  logic [RW-1:0]      row_q, wr_row_q;
  logic               bubble_q;
  vec_t               v_q, rd_q, rd_d, seed_in, seed_d, row_vec;
  vec_t               buf_q [MAX_LAYERS];
  logic               accept, last_wr, dot_vld, rd_ok;
  logic [DATA_W-1:0]  dot_data;
  logic [AW-1:0]      ra, rp;

  assign row_vec = bus.row_data;
  assign seed_in = bus.seed_vec;
  assign l_clamp = (bus.num_layers > LAYER_W'(MAX_LAYERS)) ? LAYER_W'(MAX_LAYERS)
                                                            : bus.num_layers;
  assign accept  = bus.row_valid && bus.row_ready;
  assign last_wr = dot_vld && (wr_row_q == RW'(N - 1));

  always_comb begin
    seed_d = '0;
    for (int i = 0; i < N; i++)
      seed_d[i] = bus.seed_mode ? DATA_W'(one_hot_seed(bus.seed_sel[i], FRAC_W)) : seed_in[i];
  end

  fxp_dot_row #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N(N)) u_dot (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (accept),
    .row_i      (row_vec),
    .vec_i      (v_q),
    .out_valid_o(dot_vld),
    .out_data_o (dot_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (l_clamp == '0) ? DONE : RUN;
      RUN:     if (last_wr && (layer_q + LAYER_W'(1) == layers_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The bubble after the last row lets the final dot result land before the
  // next layer's first row is multiplied against the refreshed vector.
  always_comb begin
    bus.row_ready = (state_q == RUN) && !bubble_q;
    bus.busy      = (state_q == RUN);
    bus.done      = (state_q == DONE);
  end

  assign ra    = bus.rd_addr[AW-1:0];
  assign rp    = ra - AW'(1);
  assign rd_ok = bus.rd_addr < LAYER_W'(MAX_LAYERS);

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < N; i++)
      if (rd_ok)
        rd_d[i] = bus.rd_mask[i] ? ((bus.rd_addr != '0) ? buf_q[rp][i] : '0) : buf_q[ra][i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layers_q <= '0;
      layer_q  <= '0;
      row_q    <= '0;
      wr_row_q <= '0;
      bubble_q <= 1'b0;
      v_q      <= '0;
      rd_q     <= '0;
      for (int k = 0; k < MAX_LAYERS; k++) buf_q[k] <= '0;
    end else begin
      rd_q <= rd_d;
      if (state_q == IDLE && bus.start) begin
        layers_q <= l_clamp;
        v_q      <= seed_d;
        layer_q  <= '0;
        row_q    <= '0;
        bubble_q <= 1'b0;
      end
      if (accept) begin
        wr_row_q <= row_q;
        if (row_q == RW'(N - 1)) bubble_q <= 1'b1;
        else                     row_q    <= row_q + RW'(1);
      end
      if (dot_vld) buf_q[layer_q[AW-1:0]][wr_row_q] <= dot_data;
      // Last element is still in flight in the dot register, so bypass it.
      if (last_wr) begin
        for (int i = 0; i < N - 1; i++) v_q[i] <= buf_q[layer_q[AW-1:0]][i];
        v_q[N-1] <= dot_data;
        layer_q  <= layer_q + LAYER_W'(1);
        row_q    <= '0;
        bubble_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data = rd_q;
endmodule
